// File: rtl/skew_clk_gen_if.sv
// Bundle of control and clock-output signals for skew_clk_gen.
//   EN       run request
//   LOAD     one-cycle strobe that captures DIV/SKEW
//   DIV      requested period P in CLK cycles
//   SKEW     requested phase-to-phase skew S in CLK cycles
//   CCLK     base divided clock
//   sQ0..sQ3 copies of CCLK delayed by 1..4 times S
//   RUN      generator running
//   CFG_ERR  sticky flag, last LOAD was rejected
// master drives the controls; slave is the generator.
interface skew_clk_gen_if;
    logic       EN;
    logic       LOAD;
    logic [7:0] DIV;
    logic [7:0] SKEW;
    logic       CCLK;
    logic       sQ0;
    logic       sQ1;
    logic       sQ2;
    logic       sQ3;
    logic       RUN;
    logic       CFG_ERR;

    modport master (
        output EN, LOAD, DIV, SKEW,
        input  CCLK, sQ0, sQ1, sQ2, sQ3, RUN, CFG_ERR
    );
    modport slave (
        input  EN, LOAD, DIV, SKEW,
        output CCLK, sQ0, sQ1, sQ2, sQ3, RUN, CFG_ERR
    );
endinterface

// File: rtl/skew_clk_gen.sv
// skew_clk_gen: divides CLK into a base clock CCLK of period P (H = P/2
// cycles high) and four copies sQ0..sQ3 delayed by S, 2S, 3S and 4S.
// A new (P, S) is accepted into a pending slot and only takes over at a
// period boundary, or immediately while idle, so no runt pulses appear.
// Ports:
//   CLK    reference clock, rising edge
//   RESET  synchronous, active-high
//   bus    skew_clk_gen_if.slave (EN, LOAD, DIV, SKEW in; clocks, RUN,
//          CFG_ERR out)

// One phase lane: is the lane high given the phase counter and its lag?
// Arithmetic is 10 bits wide so cnt + P - lag (max 2P-1) never truncates.
module skew_clk_phase (
    input  logic [7:0] cnt_i,
    input  logic [7:0] per_i,
    input  logic [9:0] lag_i,
    output logic       hi_o
);
    logic [9:0] sum;
    logic [9:0] per10;
    logic [9:0] ph;

    assign per10 = {2'b00, per_i};
    assign sum   = {2'b00, cnt_i} + per10 - lag_i;
    // lag < P and cnt < P, so sum lies in [1, 2P-1]; one subtract is an
    // exact modulo.
    assign ph    = (sum >= per10) ? (sum - per10) : sum;
    assign hi_o  = (ph < {3'b000, per_i[7:1]});
endmodule

module skew_clk_gen #(
    parameter logic [7:0] DIV_RST  = 8'd16,
    parameter logic [7:0] SKEW_RST = 8'd1
) (
    input  logic            CLK,
    input  logic            RESET,
    skew_clk_gen_if.slave   bus
);
    localparam int NUM_PH = 5;  // lane 0 = CCLK, lanes 1..4 = sQ0..sQ3

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          per_q, per_d;     // active P
    logic [7:0]          skw_q, skw_d;     // active S
    logic [7:0]          pper_q, pper_d;   // pending P
    logic [7:0]          pskw_q, pskw_d;   // pending S
    logic                err_q, err_d;
    logic                run_q, run_d;
    logic [NUM_PH-1:0]   ph_q, ph_d;
    logic [NUM_PH-1:0]   ph_hi;
    logic [NUM_PH-1:0][9:0] lag;

    logic [9:0] div10;
    logic [9:0] skew4;
    logic       load_ok;
    logic       wrap;

    assign div10   = {2'b00, bus.DIV};
    assign skew4   = {bus.SKEW, 2'b00};
    assign load_ok = bus.LOAD && (div10 >= 10'd2) && (skew4 < div10);
    assign wrap    = ({2'b00, cnt_q} == ({2'b00, per_q} - 10'd1));

    for (genvar k = 0; k < NUM_PH; k++) begin : g_ph
        assign lag[k] = {2'b00, skw_q} * 10'(k);
        skew_clk_phase u_ph (
            .cnt_i (cnt_q),
            .per_i (per_q),
            .lag_i (lag[k]),
            .hi_o  (ph_hi[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= DIV_RST;
            skw_q   <= SKEW_RST;
            pper_q  <= DIV_RST;
            pskw_q  <= SKEW_RST;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            skw_q   <= skw_d;
            pper_q  <= pper_d;
            pskw_q  <= pskw_d;
            err_q   <= err_d;
            run_q   <= run_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        skw_d   = skw_q;
        pper_d  = pper_q;
        pskw_d  = pskw_q;
        err_d   = err_q;
        ph_d    = '0;

        if (bus.LOAD) begin
            err_d = !load_ok;
        end
        if (load_ok) begin
            pper_d = bus.DIV;
            pskw_d = bus.SKEW;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // While idle the active slot tracks the newest legal config,
                // so a LOAD issued together with EN shapes the first period.
                if (load_ok) begin
                    per_d = bus.DIV;
                    skw_d = bus.SKEW;
                end else begin
                    per_d = pper_q;
                    skw_d = pskw_q;
                end
                if (bus.EN) state_d = RUN;
            end
            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    // Old pending value: a LOAD in this very cycle waits one
                    // more period.
                    per_d = pper_q;
                    skw_d = pskw_q;
                    if (!bus.EN) state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (state_d == RUN) ph_d = ph_hi;
            end
            default: state_d = IDLE;
        endcase
    end

    assign run_d = (state_d == RUN);

    assign bus.CCLK    = ph_q[0];
    assign bus.sQ0     = ph_q[1];
    assign bus.sQ1     = ph_q[2];
    assign bus.sQ2     = ph_q[3];
    assign bus.sQ3     = ph_q[4];
    assign bus.RUN     = run_q;
    assign bus.CFG_ERR = err_q;
endmodule

// File: tb/tb_skew_clk_gen.sv
module tb_skew_clk_gen;
    logic CLK = 1'b0;
    logic RESET = 1'b1;

    skew_clk_gen_if bus ();

    skew_clk_gen #(.DIV_RST(8'd16), .SKEW_RST(8'd1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model state (value during the cycle about to be driven)
    int m_run = 0, m_cnt = 0, m_p = 16, m_s = 1, m_pp = 16, m_ps = 1, m_err = 0;

    logic [6:0] exp_q[$];   // {CCLK, sQ3, sQ2, sQ1, sQ0, RUN, CFG_ERR}
    int n_chk = 0;
    int n_fail = 0;
    int n_cyc = 0;

    function automatic bit lane_hi(int cnt, int p, int lag);
        return ((cnt + p - lag) % p) < (p / 2);
    endfunction

    // Drive one cycle of stimulus and push the model's prediction of the
    // outputs that appear after the following rising edge.
    task automatic cyc(input bit rst, input bit en, input bit ld, input int div, input int skew);
        bit legal;
        int nrun, ncnt, np, ns, npp, nps, nerr;
        logic [3:0] sq;
        logic cclk;
        @(negedge CLK);
        RESET    = rst;
        bus.EN   = en;
        bus.LOAD = ld;
        bus.DIV  = 8'(div);
        bus.SKEW = 8'(skew);
        cclk = 1'b0;
        sq   = 4'b0;
        if (rst) begin
            nrun = 0; ncnt = 0; np = 16; ns = 1; npp = 16; nps = 1; nerr = 0;
        end else begin
            legal = ld && div >= 2 && 4 * skew < div;
            nerr  = ld ? !legal : m_err;
            npp   = legal ? div  : m_pp;
            nps   = legal ? skew : m_ps;
            if (!m_run) begin
                nrun = en; ncnt = 0;
                np = legal ? div : m_pp;
                ns = legal ? skew : m_ps;
            end else begin
                bit last;
                last = (m_cnt == m_p - 1);
                nrun = !(last && !en);
                ncnt = last ? 0 : m_cnt + 1;
                np = last ? m_pp : m_p;
                ns = last ? m_ps : m_s;
                if (nrun) begin
                    cclk = lane_hi(m_cnt, m_p, 0);
                    for (int k = 0; k < 4; k++) sq[k] = lane_hi(m_cnt, m_p, (k + 1) * m_s);
                end
            end
        end
        exp_q.push_back({cclk, sq, nrun[0], nerr[0]});
        m_run = nrun; m_cnt = ncnt; m_p = np; m_s = ns; m_pp = npp; m_ps = nps; m_err = nerr;
    endtask

    // Monitor: every cycle the DUT presents a fresh output vector.
    always @(posedge CLK) begin
        logic [6:0] e, g;
        #1;
        n_cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {bus.CCLK, bus.sQ3, bus.sQ2, bus.sQ1, bus.sQ0, bus.RUN, bus.CFG_ERR};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got {CCLK,sQ3..0,RUN,ERR}=%b required %b", n_cyc, g, e);
            end
        end
    end

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(0, en, 0, 0, 0);
    endtask

    task automatic wait_cnt(input int target, input int maxc, input string nm);
        int i;
        i = 0;
        while (!(m_run == 1 && m_cnt == target) && i < maxc) begin
            cyc(0, 1, 0, 0, 0);
            i++;
        end
        n_chk++;
        if (!(m_run == 1 && m_cnt == target)) begin
            n_fail++;
            $display("FAIL wait_%s cnt=%0d required %0d", nm, m_cnt, target);
        end
    endtask

    initial begin
        int i;
        bus.EN = 0; bus.LOAD = 0; bus.DIV = 0; bus.SKEW = 0;
        // reset, with EN and LOAD asserted to show reset overrides them
        cyc(1, 1, 1, 10, 2);
        cyc(1, 0, 0, 0, 0);
        idle(3, 0);
        // defaults
        idle(50, 1);
        // reconfigure mid-period
        wait_cnt(5, 40, "reconf");
        cyc(0, 1, 1, 10, 2);
        idle(45, 1);
        // illegal / legal / illegal loads
        cyc(0, 1, 1, 8, 2);
        idle(25, 1);
        cyc(0, 1, 1, 12, 2);
        idle(30, 1);
        cyc(0, 1, 1, 1, 0);
        idle(30, 1);
        // clean stop at P = 16
        cyc(1, 0, 0, 0, 0);
        idle(3, 1);
        wait_cnt(3, 40, "stop");
        i = 0;
        while (m_run == 1 && i < 40) begin cyc(0, 0, 0, 0, 0); i++; end
        idle(5, 0);
        // LOAD together with EN from IDLE, large wrapping config
        cyc(0, 1, 1, 255, 63);
        idle(600, 1);
        wait_cnt(100, 300, "rst100");
        cyc(1, 1, 0, 0, 0);
        idle(40, 1);
        // LOAD on the boundary cycle
        wait_cnt(15, 40, "bound");
        cyc(0, 1, 1, 6, 1);
        idle(40, 1);
        // random
        for (int r = 0; r < 3000; r++) begin
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 19) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 24), $urandom_range(0, 7));
        end
        idle(2, 0);
        i = 0;
        while (exp_q.size() != 0 && i < 10) begin @(posedge CLK); i++; end
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
